fsab_initiator: RTL and testbench
=================================

# fsab_initiator

Generic FSAB bus master: accepts simple read/write commands from a local client, issues them on the `fsabo_*` request channel under credit flow control, streams write data, and returns matching `fsabi_*` read data to the client. It sits between a client (cache refill, DMA, framebuffer fetch) and the FSAB arbiter, and is the initiator counterpart of the FSAB memory/slave models.

## Interface
- `FSAB_DID`, default 0: device ID driven on `fsabo_did`. Only `fsabi_*` beats with this DID are accepted.
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted this cycle when `cmd_valid` is also high.
- `cmd_write`  in  1  1 = `FSAB_WRITE`, 0 = `FSAB_READ`.
- `cmd_addr`  in  FSAB_ADDR_HI+1  byte address.
- `cmd_len`  in  FSAB_LEN_HI+1  words, 1..FSAB_LEN_MAX.
- `cmd_subdid`  in  FSAB_DID_HI+1  tag returned with read data.
- `wr_valid`, `wr_ready`  in/out  1  write-data handshake.
- `wr_data`  in  FSAB_DATA_HI+1; `wr_mask`  in  FSAB_MASK_HI+1.
- `rd_valid`  out  1; `rd_data`  out  FSAB_DATA_HI+1; `rd_subdid`  out  FSAB_DID_HI+1.
- `busy`  out  1  write burst in progress or read beats outstanding.
- `fsabo_valid`, `fsabo_mode`, `fsabo_did`, `fsabo_subdid`, `fsabo_addr`, `fsabo_len`, `fsabo_data`, `fsabo_mask`: outputs with FSAB widths.
- `fsabo_credit`  in  1  one-cycle pulse: slave freed one request slot.
- `fsabi_valid`, `fsabi_did`, `fsabi_subdid`, `fsabi_data`: inputs with FSAB widths.

## Operation
- Credit counter: width FSAB_CREDITS_HI+1. Reset value is FSAB_INITIAL_CREDITS. It decrements on each header issued and increments on each `fsabo_credit` pulse. If both occur in the same cycle, the count is unchanged. A count above FSAB_INITIAL_CREDITS is a `$error`.
- State machine, IDLE / WBURST:
  - IDLE: `cmd_ready = (credits != 0) && (!cmd_write || wr_valid)`.
    - A write also consumes word 0 from the `wr_*` port in the same cycle; `wr_ready` equals `cmd_ready && cmd_write` in IDLE.
    - On accept, the header beat is registered out. Write with `cmd_len > 1` goes to WBURST with `remaining = cmd_len - 1`. Read, or write with `cmd_len == 1`, stays in IDLE.
  - WBURST: `cmd_ready = 0`, `wr_ready = 1`.
    - Each accepted `wr_*` beat produces one `fsabo_valid` beat next cycle with mode, addr, len and subdid held from the header, and decrements `remaining`.
    - Exit to IDLE after the beat where `remaining` goes 1→0.
    - Gaps (`wr_valid` low) drop `fsabo_valid` and are legal.
- Read header: `fsabo_data = 0`, `fsabo_mask = 0`. It is exactly one `fsabo_valid` beat.
- Read tracker: `rd_outstanding`, width FSAB_LEN_HI+FSAB_CREDITS_HI+2. It adds `cmd_len` on read accept and subtracts 1 per accepted `fsabi` beat. If both occur in the same cycle, it applies `+cmd_len-1`. An `fsabi` beat with our DID while `rd_outstanding == 0` is a `$error`, and the counter saturates at 0.
- `busy = (state == WBURST) || (rd_outstanding != 0)`.
- `cmd_len == 0` is a `$error`. The command is still accepted and treated as length 1.

## Timing
- All `fsabo_*`, `rd_*` and `busy` outputs are registered.
- After reset, every output is 0 except `cmd_ready` and `wr_ready`, which are combinational as above. The first reset cycle forces both to 0.
- Command or `wr_*` accept in cycle N gives the `fsabo_valid` beat in N+1. Back-to-back reads give headers on consecutive cycles while credits last.
- An `fsabi` beat with matching DID in cycle N gives `rd_valid` in N+1, with data and subdid passed unchanged. There is no `rd_*` backpressure.
- Non-matching DID beats are ignored entirely.
- A credit pulse in cycle N permits an accept in N+1 when the count was 0. There is no same-cycle bypass.
- `rst` mid-burst or mid-read: state goes to IDLE, credits return to initial, `rd_outstanding` clears, and `fsabo_valid` is 0 in the next cycle. The FSAB slave must be reset together with this block.

## Structure
- FSAB widths and constants come from the shared `fsab_defines.vh`: FSAB_*_HI, FSAB_READ, FSAB_WRITE, FSAB_LEN_MAX, FSAB_INITIAL_CREDITS. No new constants go there.
- Sub-module `fsab_credit_ctr` holds the credit counter with inc, dec, nonzero and overflow check. It is reusable by other initiators.

## Test plan
- Reset, then read addr `0x100`, len 4, subdid 3 → one `fsabo` beat (mode READ, len 4). Model returns 4 beats → `rd_valid` ×4 with subdid 3, data in order; `busy` drops the cycle after the 4th.
- Write addr `0x40`, len 3, with `wr_valid` gap after word 1 → exactly 3 `fsabo_valid` beats carrying words 0, 1, 2 in order; no beat during the gap.
- FSAB_INITIAL_CREDITS=4, no credit returns → 4 reads accepted, the 5th stalls (`cmd_ready = 0`). Credit pulse in N → accept in N+1.
- Credit pulse coincident with a header issue at count 2 → count stays 2.
- `fsabi` beats with DID ≠ FSAB_DID interleaved with our read data → ignored; `rd_outstanding` is unaffected by them.
- `rst` asserted in WBURST with `remaining = 2` → next cycle `fsabo_valid = 0`, `busy = 0`, and credits back at initial.

Source files
------------

// File: rtl/fsab_initiator_pkg.sv
// FSAB bus widths, opcodes and credit constants shared by FSAB initiators,
// plus the initiator FSM state type.
package fsab_initiator_pkg;

    localparam int FSAB_ADDR_HI         = 30;
    localparam int FSAB_DATA_HI         = 63;
    localparam int FSAB_MASK_HI         = 7;
    localparam int FSAB_DID_HI          = 3;
    localparam int FSAB_LEN_HI          = 3;
    localparam int FSAB_CREDITS_HI      = 2;
    localparam int FSAB_INITIAL_CREDITS = 4;
    localparam int FSAB_LEN_MAX         = 8;

    localparam logic FSAB_READ  = 1'b0;
    localparam logic FSAB_WRITE = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_WBURST = 1'b1
    } fsab_state_e;

endpackage

// File: rtl/fsab_credit_ctr.sv
// Request-slot credit counter for an FSAB initiator: one credit per header
// issued, one back per slave credit pulse; flags a return beyond the initial pool.
module fsab_credit_ctr
    import fsab_initiator_pkg::*;
#(
    parameter int WIDTH = FSAB_CREDITS_HI + 1,
    parameter int INIT  = FSAB_INITIAL_CREDITS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_nonzero
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_overflow;

    // A simultaneous issue and return cancel out.
    always_comb begin
        w_count_nxt = r_count;
        w_overflow  = 1'b0;
        if (i_inc && !i_dec) begin
            w_count_nxt = r_count + WIDTH'(1);
            w_overflow  = (r_count >= WIDTH'(INIT));
        end else if (i_dec && !i_inc) begin
            w_count_nxt = r_count - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= WIDTH'(INIT);
        end else begin
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_overflow) begin
            $error("fsab_credit_ctr: credit count exceeds initial pool");
        end
    end

    assign o_nonzero = (r_count != '0);

endmodule

// File: rtl/fsab_initiator.sv
// FSAB bus master: turns client read/write commands into credit-limited
// fsabo request beats and forwards matching fsabi read data to the client.
module fsab_initiator
    import fsab_initiator_pkg::*;
#(
    parameter logic [FSAB_DID_HI:0] FSAB_DID = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [FSAB_ADDR_HI:0]   cmd_addr,
    input  logic [FSAB_LEN_HI:0]    cmd_len,
    input  logic [FSAB_DID_HI:0]    cmd_subdid,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [FSAB_DATA_HI:0]   wr_data,
    input  logic [FSAB_MASK_HI:0]   wr_mask,
    output logic                    rd_valid,
    output logic [FSAB_DATA_HI:0]   rd_data,
    output logic [FSAB_DID_HI:0]    rd_subdid,
    output logic                    busy,
    output logic                    fsabo_valid,
    output logic                    fsabo_mode,
    output logic [FSAB_DID_HI:0]    fsabo_did,
    output logic [FSAB_DID_HI:0]    fsabo_subdid,
    output logic [FSAB_ADDR_HI:0]   fsabo_addr,
    output logic [FSAB_LEN_HI:0]    fsabo_len,
    output logic [FSAB_DATA_HI:0]   fsabo_data,
    output logic [FSAB_MASK_HI:0]   fsabo_mask,
    input  logic                    fsabo_credit,
    input  logic                    fsabi_valid,
    input  logic [FSAB_DID_HI:0]    fsabi_did,
    input  logic [FSAB_DID_HI:0]    fsabi_subdid,
    input  logic [FSAB_DATA_HI:0]   fsabi_data
);

    localparam int LEN_W = FSAB_LEN_HI + 1;
    localparam int RD_W  = FSAB_LEN_HI + FSAB_CREDITS_HI + 2;

    fsab_state_e        r_state;
    fsab_state_e        w_state_nxt;
    logic [LEN_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   w_remaining_nxt;
    logic [RD_W-1:0]    r_rd_out;
    logic [RD_W-1:0]    w_rd_out_nxt;
    logic [RD_W-1:0]    w_rd_add;
    logic [LEN_W-1:0]   w_len_eff;
    logic               w_credit_ok;
    logic               w_idle_ok;
    logic               w_cmd_acc;
    logic               w_wr_acc;
    logic               w_burst_acc;
    logic               w_rd_hit;

    fsab_credit_ctr #(
        .WIDTH (FSAB_CREDITS_HI + 1),
        .INIT  (FSAB_INITIAL_CREDITS)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (fsabo_credit),
        .i_dec     (w_cmd_acc),
        .o_nonzero (w_credit_ok)
    );

    // A zero-length command is flagged but still issued as a single word.
    assign w_len_eff = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
    assign w_idle_ok = w_credit_ok && (!cmd_write || wr_valid);

    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    cmd_ready = w_idle_ok;
                    wr_ready  = w_idle_ok && cmd_write;
                end
                ST_WBURST: begin
                    wr_ready  = 1'b1;
                end
                default: begin
                    cmd_ready = 1'b0;
                    wr_ready  = 1'b0;
                end
            endcase
        end
    end

    assign w_cmd_acc   = cmd_valid && cmd_ready;
    assign w_wr_acc    = wr_valid && wr_ready;
    assign w_burst_acc = w_wr_acc && (r_state == ST_WBURST);
    assign w_rd_hit    = fsabi_valid && (fsabi_did == FSAB_DID);

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_acc && cmd_write && (w_len_eff > LEN_W'(1))) begin
                    w_state_nxt     = ST_WBURST;
                    w_remaining_nxt = w_len_eff - LEN_W'(1);
                end
            end
            ST_WBURST: begin
                if (w_wr_acc) begin
                    w_remaining_nxt = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A stray read beat with nothing outstanding subtracts nothing.
    always_comb begin
        w_rd_add = (w_cmd_acc && !cmd_write) ? RD_W'(w_len_eff) : '0;
        if (w_rd_hit && (r_rd_out == '0)) begin
            w_rd_out_nxt = w_rd_add;
        end else begin
            w_rd_out_nxt = r_rd_out + w_rd_add - RD_W'(w_rd_hit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_rd_out    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_rd_out    <= w_rd_out_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsabo_valid  <= 1'b0;
            fsabo_mode   <= 1'b0;
            fsabo_did    <= '0;
            fsabo_subdid <= '0;
            fsabo_addr   <= '0;
            fsabo_len    <= '0;
            fsabo_data   <= '0;
            fsabo_mask   <= '0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_subdid    <= '0;
            busy         <= 1'b0;
        end else begin
            fsabo_valid <= 1'b0;
            if (w_cmd_acc) begin
                fsabo_valid  <= 1'b1;
                fsabo_mode   <= cmd_write ? FSAB_WRITE : FSAB_READ;
                fsabo_did    <= FSAB_DID;
                fsabo_subdid <= cmd_subdid;
                fsabo_addr   <= cmd_addr;
                fsabo_len    <= w_len_eff;
                fsabo_data   <= cmd_write ? wr_data : '0;
                fsabo_mask   <= cmd_write ? wr_mask : '0;
            end else if (w_burst_acc) begin
                // Header fields stay as registered for the whole burst.
                fsabo_valid  <= 1'b1;
                fsabo_data   <= wr_data;
                fsabo_mask   <= wr_mask;
            end
            rd_valid <= w_rd_hit;
            if (w_rd_hit) begin
                rd_data   <= fsabi_data;
                rd_subdid <= fsabi_subdid;
            end
            busy <= (w_state_nxt == ST_WBURST) || (w_rd_out_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_cmd_acc && (cmd_len == '0)) begin
                $error("fsab_initiator: zero-length command");
            end
            if (w_rd_hit && (r_rd_out == '0)) begin
                $error("fsab_initiator: read data with no reads outstanding");
            end
        end
    end

endmodule

// File: tb/tb_fsab_initiator.sv
// Directed bench for fsab_initiator: a scoreboard of expected fsabo and rd
// beats filled by the drivers and drained by a negedge monitor.
module tb_fsab_initiator;
    import fsab_initiator_pkg::*;

    localparam logic [3:0] DID = 4'd5;

    typedef struct packed {
        logic        mode;
        logic [3:0]  subdid;
        logic [30:0] addr;
        logic [3:0]  len;
        logic [63:0] data;
        logic [7:0]  mask;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [30:0] cmd_addr = '0;
    logic [3:0]  cmd_len = 4'd1;
    logic [3:0]  cmd_subdid = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [63:0] wr_data = '0;
    logic [7:0]  wr_mask = '0;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic [3:0]  rd_subdid;
    logic        busy;
    logic        fsabo_valid;
    logic        fsabo_mode;
    logic [3:0]  fsabo_did;
    logic [3:0]  fsabo_subdid;
    logic [30:0] fsabo_addr;
    logic [3:0]  fsabo_len;
    logic [63:0] fsabo_data;
    logic [7:0]  fsabo_mask;
    logic        fsabo_credit = 1'b0;
    logic        fsabi_valid = 1'b0;
    logic [3:0]  fsabi_did = '0;
    logic [3:0]  fsabi_subdid = '0;
    logic [63:0] fsabi_data = '0;

    beat_t       exp_q[$];
    logic [67:0] exp_rd_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [30:0] cur_addr;
    logic [3:0]  cur_len;
    logic [3:0]  cur_sub;

    fsab_initiator #(.FSAB_DID(DID)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_subdid(cmd_subdid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_subdid(rd_subdid), .busy(busy),
        .fsabo_valid(fsabo_valid), .fsabo_mode(fsabo_mode), .fsabo_did(fsabo_did),
        .fsabo_subdid(fsabo_subdid), .fsabo_addr(fsabo_addr), .fsabo_len(fsabo_len),
        .fsabo_data(fsabo_data), .fsabo_mask(fsabo_mask), .fsabo_credit(fsabo_credit),
        .fsabi_valid(fsabi_valid), .fsabi_did(fsabi_did), .fsabi_subdid(fsabi_subdid),
        .fsabi_data(fsabi_data)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        wr_valid = 1'b0;
        fsabi_valid = 1'b0;
        fsabo_credit = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drive one command (with word 0 for writes) until accepted.
    task automatic issue(input logic wr, input logic [30:0] addr, input logic [3:0] len,
                         input logic [3:0] sub, input logic [63:0] d, input logic [7:0] m);
        bit ok = 1'b0;
        beat_t b;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr = addr;
        cmd_len = len;
        cmd_subdid = sub;
        wr_valid = wr;
        wr_data = d;
        wr_mask = m;
        cur_addr = addr;
        cur_len = len;
        cur_sub = sub;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                b.mode = wr;
                b.subdid = sub;
                b.addr = addr;
                b.len = len;
                b.data = wr ? d : 64'd0;
                b.mask = wr ? m : 8'd0;
                exp_q.push_back(b);
            end
            tick();
        end
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        wr_valid = 1'b0;
        check("cmd_accept", 64'(ok), 64'd1);
    endtask

    task automatic send_wdata(input logic [63:0] d, input logic [7:0] m);
        bit ok = 1'b0;
        beat_t b;
        wr_valid = 1'b1;
        wr_data = d;
        wr_mask = m;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                ok = 1'b1;
                b.mode = 1'b1;
                b.subdid = cur_sub;
                b.addr = cur_addr;
                b.len = cur_len;
                b.data = d;
                b.mask = m;
                exp_q.push_back(b);
            end
            tick();
        end
        wr_valid = 1'b0;
        check("wr_accept", 64'(ok), 64'd1);
    endtask

    task automatic send_rd(input logic [3:0] did, input logic [3:0] sub, input logic [63:0] d);
        fsabi_valid = 1'b1;
        fsabi_did = did;
        fsabi_subdid = sub;
        fsabi_data = d;
        @(negedge clk);
        if (did == DID) exp_rd_q.push_back({sub, d});
        tick();
        fsabi_valid = 1'b0;
    endtask

    task automatic expect_stall(input string name);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_len = 4'd1;
        @(negedge clk);
        check(name, 64'(cmd_ready), 64'd0);
        cmd_valid = 1'b0;
        tick();
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        beat_t e;
        beat_t a;
        logic [67:0] er;
        if (fsabo_valid) begin
            n_tests++;
            a = {fsabo_mode, fsabo_subdid, fsabo_addr, fsabo_len, fsabo_data, fsabo_mask};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fsabo_beat: unexpected beat %0h, none required", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e || fsabo_did !== DID) begin
                    n_fail++;
                    $display("FAIL fsabo_beat: actual %0h did %0h required %0h did %0h",
                             a, fsabo_did, e, DID);
                end
            end
        end
        if (rd_valid) begin
            n_tests++;
            if (exp_rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_beat: unexpected %0h/%0h, none required", rd_subdid, rd_data);
            end else begin
                er = exp_rd_q.pop_front();
                if ({rd_subdid, rd_data} !== er) begin
                    n_fail++;
                    $display("FAIL rd_beat: actual %0h required %0h", {rd_subdid, rd_data}, er);
                end
            end
        end
    end

    initial begin
        // Reset: handshakes forced low even with a command present.
        cmd_valid = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        cmd_valid = 1'b0;
        do_reset();
        @(negedge clk);
        check("reset_fsabo_valid", 64'(fsabo_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_fsabo_did", 64'(fsabo_did), 64'd0);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        tick();

        // Read 0x100 len 4 with foreign-DID beats interleaved.
        issue(1'b0, 31'h100, 4'd4, 4'd3, 64'd0, 8'd0);
        @(negedge clk);
        check("read_busy", 64'(busy), 64'd1);
        tick();
        send_rd(DID, 4'd3, 64'hA0A0_0000_0000_0001);
        send_rd(4'd2, 4'd9, 64'hDEAD_0000_0000_0001);
        send_rd(DID, 4'd3, 64'hA0A0_0000_0000_0002);
        send_rd(DID, 4'd3, 64'hA0A0_0000_0000_0003);
        send_rd(4'd2, 4'd9, 64'hDEAD_0000_0000_0002);
        send_rd(4'd7, 4'd3, 64'hDEAD_0000_0000_0003);
        @(negedge clk);
        check("busy_before_last", 64'(busy), 64'd1);
        tick();
        send_rd(DID, 4'd3, 64'hA0A0_0000_0000_0004);
        @(negedge clk);
        check("busy_after_last", 64'(busy), 64'd0);
        tick();

        // Write 0x40 len 3 with a gap after word 1.
        issue(1'b1, 31'h40, 4'd3, 4'd2, 64'h1111_0000_0000_0000, 8'hF0);
        cmd_valid = 1'b1;
        @(negedge clk);
        check("wburst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("wburst_busy", 64'(busy), 64'd1);
        cmd_valid = 1'b0;
        tick();
        send_wdata(64'h2222_0000_0000_0000, 8'h0F);
        tick();
        send_wdata(64'h3333_0000_0000_0000, 8'hFF);
        @(negedge clk);
        check("write_done_busy", 64'(busy), 64'd0);
        tick();

        // Credit exhaustion, then a pulse in N allows accept in N+1.
        do_reset();
        for (int i = 0; i < 4; i++) issue(1'b0, 31'h200 + 31'(i * 8), 4'd1, 4'd1, 64'd0, 8'd0);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr = 31'h300;
        cmd_len = 4'd1;
        cmd_subdid = 4'd4;
        @(negedge clk);
        check("stall_5th", 64'(cmd_ready), 64'd0);
        tick();
        fsabo_credit = 1'b1;
        @(negedge clk);
        check("no_credit_bypass", 64'(cmd_ready), 64'd0);
        tick();
        fsabo_credit = 1'b0;
        @(negedge clk);
        check("credit_accept", 64'(cmd_ready), 64'd1);
        exp_q.push_back('{mode: 1'b0, subdid: 4'd4, addr: 31'h300, len: 4'd1,
                          data: 64'd0, mask: 8'd0});
        tick();
        cmd_valid = 1'b0;
        tick();

        // Credit pulse coincident with a header at count 2 leaves it at 2.
        do_reset();
        issue(1'b0, 31'h400, 4'd1, 4'd0, 64'd0, 8'd0);
        issue(1'b0, 31'h404, 4'd1, 4'd0, 64'd0, 8'd0);
        fsabo_credit = 1'b1;
        issue(1'b0, 31'h408, 4'd1, 4'd0, 64'd0, 8'd0);
        fsabo_credit = 1'b0;
        issue(1'b0, 31'h40C, 4'd2, 4'd1, 64'd0, 8'd0);
        issue(1'b0, 31'h410, 4'd1, 4'd1, 64'd0, 8'd0);
        expect_stall("stall_after_coincident");

        // Reset in the middle of a write burst with two words left.
        do_reset();
        issue(1'b1, 31'h80, 4'd4, 4'd6, 64'h5555_0000_0000_0000, 8'h01);
        send_wdata(64'h6666_0000_0000_0000, 8'h02);
        rst = 1'b1;
        @(negedge clk);
        check("rst_wr_ready_burst", 64'(wr_ready), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_burst_fsabo_valid", 64'(fsabo_valid), 64'd0);
        check("rst_burst_busy", 64'(busy), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) issue(1'b0, 31'h500 + 31'(i * 8), 4'd1, 4'd2, 64'd0, 8'd0);
        expect_stall("credits_restored");

        repeat (3) tick();
        check("fsabo_queue_empty", 64'(exp_q.size()), 64'd0);
        check("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
